// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the issue-side requesters and the shared ALU arbiter.
// Per-requester fields are packed side by side, requester i at slice i.
interface alu_arbiter_if #(
  parameter int NREQ = 2
) ();
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [3*NREQ-1:0] req_op;
  logic [8*NREQ-1:0] req_a;
  logic [8*NREQ-1:0] req_b;
  logic [NREQ-1:0]   resp_valid;
  logic [NREQ-1:0]   resp_ready;
  logic [7:0]        resp_rslt;
  logic              resp_zero;
  logic              busy;

  modport master (
    output req_valid, req_op, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_rslt, resp_zero, busy
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_rslt, resp_zero, busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one 8-bit ALU (ADD, LSH, RSH, XOR) among NREQ requesters.
// One operation in flight: IDLE grants, EXEC computes, RESP holds the result until consumed.
module alu_arbiter #(
  parameter int NREQ = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_arbiter_if.slave bus
);

  localparam int PW = $clog2(NREQ);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_LSH = 3'd1;
  localparam logic [2:0] OP_RSH = 3'd2;
  localparam logic [2:0] OP_XOR = 3'd3;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [PW-1:0] ptr;
  logic [PW-1:0] win;
  logic [PW-1:0] gnt_idx;
  logic          gnt_found;
  logic          accept;
  logic [2:0]    sel_op;
  logic [7:0]    sel_a;
  logic [7:0]    sel_b;
  logic [2:0]    op_q;
  logic [7:0]    a_q;
  logic [7:0]    b_q;
  logic [7:0]    alu_res;
  logic [7:0]    rslt_q;
  logic          zero_q;
  logic          busy_q;
  logic [NREQ-1:0] rdy;
  logic [NREQ-1:0] rv;

  function automatic logic [PW-1:0] wrap_inc(
    input logic [PW-1:0] p,
    input int            k
  );
    int s;
    s = int'(p) + k;
    if (s >= NREQ) s = s - NREQ;
    return PW'(s);
  endfunction

  // First valid index at or after ptr, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!gnt_found && bus.req_valid[wrap_inc(ptr, k)]) begin
        gnt_found = 1'b1;
        gnt_idx   = wrap_inc(ptr, k);
      end
    end
  end

  assign sel_op = bus.req_op[3*int'(gnt_idx) +: 3];
  assign sel_a  = bus.req_a[8*int'(gnt_idx) +: 8];
  assign sel_b  = bus.req_b[8*int'(gnt_idx) +: 8];

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    unique case (state)
      IDLE: begin
        if (gnt_found && rst_n) begin
          accept   = 1'b1;
          state_nx = EXEC;
        end
      end
      EXEC: state_nx = RESP;
      RESP: begin
        if (bus.resp_ready[win]) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    rdy = '0;
    rv  = '0;
    if (accept) rdy[gnt_idx] = 1'b1;
    if (state == RESP) rv[win] = 1'b1;
  end

  always_comb begin
    alu_res = '0;
    case (op_q)
      OP_ADD:  alu_res = a_q + b_q;
      OP_LSH:  alu_res = a_q << b_q[1:0];
      OP_RSH:  alu_res = a_q >> b_q[1:0];
      OP_XOR:  alu_res = a_q ^ b_q;
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy_q <= 1'b0;
    end else begin
      state  <= state_nx;
      busy_q <= (state_nx != IDLE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr    <= '0;
      win    <= '0;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      rslt_q <= '0;
      zero_q <= 1'b0;
    end else begin
      if (accept) begin
        win  <= gnt_idx;
        ptr  <= wrap_inc(gnt_idx, 1);
        op_q <= sel_op;
        a_q  <= sel_a;
        b_q  <= sel_b;
      end
      if (state == EXEC) begin
        rslt_q <= alu_res;
        zero_q <= (alu_res == 8'd0);
      end
    end
  end

  assign bus.req_ready  = rdy;
  assign bus.resp_valid = rv;
  assign bus.resp_rslt  = rslt_q;
  assign bus.resp_zero  = zero_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter (NREQ=3) with a response scoreboard.
// A negedge monitor models the round-robin pointer and the ALU.
module tb_alu_arbiter;
  localparam int N = 3;
  localparam logic [2:0] ADD = 3'd0;
  localparam logic [2:0] LSH = 3'd1;
  localparam logic [2:0] RSH = 3'd2;
  localparam logic [2:0] XOR = 3'd3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_arbiter_if #(.NREQ(N)) bus ();
  alu_arbiter #(.NREQ(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int         idx;
    logic [7:0] rslt;
    logic       z;
    int         acc;
  } exp_t;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   mptr = 0;
  bit   in_resp = 1'b0;
  exp_t sb[$];
  int   gq[$];
  int   aq[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] model(
    input logic [2:0] op,
    input logic [7:0] a,
    input logic [7:0] b
  );
    case (op)
      ADD:     return a + b;
      LSH:     return a << b[1:0];
      RSH:     return a >> b[1:0];
      XOR:     return a ^ b;
      default: return 8'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: grant legality, scoreboard push on accept, compare on response.
  always @(negedge clk) begin
    int   g;
    int   want;
    exp_t e;
    if (rst_n) begin
      chk("ready_onehot0", 32'($onehot0(bus.req_ready)), 1);
      if (bus.req_ready != '0) begin
        g = -1;
        want = -1;
        for (int k = 0; k < N; k++) begin
          if (bus.req_ready[k]) g = k;
          if (want < 0 && bus.req_valid[(mptr + k) % N]) want = (mptr + k) % N;
        end
        chk("ready_when_busy", 32'(bus.busy), 0);
        chk("grant_rr", g, want);
        chk("ready_has_valid", 32'(bus.req_valid[g]), 1);
        e.idx  = g;
        e.rslt = model(bus.req_op[3*g +: 3], bus.req_a[8*g +: 8],
                       bus.req_b[8*g +: 8]);
        e.z    = (e.rslt == 8'd0);
        e.acc  = cyc;
        sb.push_back(e);
        gq.push_back(g);
        aq.push_back(cyc);
        mptr = (g + 1) % N;
      end
      if (bus.resp_valid != '0) begin
        chk("busy_in_resp", 32'(bus.busy), 1);
        if (sb.size() == 0) begin
          chk("resp_unexpected", 32'(bus.resp_valid), 0);
        end else begin
          chk("resp_idx", 32'(bus.resp_valid), 32'(1) << sb[0].idx);
          if (!in_resp) begin
            chk("latency", cyc - sb[0].acc, 2);
            in_resp = 1'b1;
          end
          chk("resp_rslt", 32'(bus.resp_rslt), 32'(sb[0].rslt));
          chk("resp_zero", 32'(bus.resp_zero), 32'(sb[0].z));
          if (bus.resp_ready[sb[0].idx]) begin
            void'(sb.pop_front());
            in_resp = 1'b0;
          end
        end
      end
    end
  end

  task automatic drive(input int i, input logic [2:0] op,
                       input logic [7:0] a, input logic [7:0] b);
    bus.req_valid[i]      = 1'b1;
    bus.req_op[3*i +: 3]  = op;
    bus.req_a[8*i +: 8]   = a;
    bus.req_b[8*i +: 8]   = b;
  endtask

  task automatic wait_ready(input int i, input string tag);
    bit seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus.req_ready[i]) begin
        seen = 1'b1;
        break;
      end
    end
    chk(tag, 32'(seen), 1);
    @(posedge clk);
    #1;
    bus.req_valid[i] = 1'b0;
  endtask

  task automatic wait_rv(input int i, input string tag);
    bit seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus.resp_valid[i]) begin
        seen = 1'b1;
        break;
      end
    end
    chk(tag, 32'(seen), 1);
  endtask

  task automatic expect_resp(input int i, input logic [7:0] r,
                             input logic z, input string tag);
    wait_rv(i, {tag, "_rv"});
    chk({tag, "_rslt"}, 32'(bus.resp_rslt), 32'(r));
    chk({tag, "_zero"}, 32'(bus.resp_zero), 32'(z));
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string tag);
    bit ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (sb.size() == 0 && !bus.busy && bus.resp_valid == '0) begin
        ok = 1'b1;
        break;
      end
    end
    chk(tag, 32'(ok), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int i, input logic [2:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] r,
                       input logic z, input string tag);
    drive(i, op, a, b);
    wait_ready(i, {tag, "_ready"});
    expect_resp(i, r, z, tag);
    wait_done({tag, "_done"});
  endtask

  task automatic check_zero_outs(input string tag);
    chk({tag, "_req_ready"}, 32'(bus.req_ready), 0);
    chk({tag, "_resp_valid"}, 32'(bus.resp_valid), 0);
    chk({tag, "_rslt"}, 32'(bus.resp_rslt), 0);
    chk({tag, "_zero"}, 32'(bus.resp_zero), 0);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid  = '0;
    bus.req_op     = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.resp_ready = '1;
    rst_n = 1'b0;
    #1;
    check_zero_outs("reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: ADD with carry discarded, ready in the same cycle
    drive(0, ADD, 8'hF0, 8'h20);
    @(negedge clk);
    chk("t1_ready_same_cycle", 32'(bus.req_ready), 32'b001);
    @(posedge clk);
    #1;
    bus.req_valid[0] = 1'b0;
    expect_resp(0, 8'h10, 1'b0, "t1_add");
    wait_done("t1_add_done");
    issue(0, XOR, 8'h5A, 8'h5A, 8'h00, 1'b1, "t1_xor");

    // 2: shift amount masking and undefined opcode
    issue(0, LSH, 8'h81, 8'h05, 8'h02, 1'b0, "t2_lsh");
    issue(0, RSH, 8'h80, 8'h03, 8'h10, 1'b0, "t2_rsh");
    issue(2, 3'b111, 8'h12, 8'h34, 8'h00, 1'b1, "t2_bad_op");

    // 3: round-robin between 0 and 1 held continuously (ptr is 0 here)
    gq.delete();
    aq.delete();
    drive(0, ADD, 8'h01, 8'h01);
    drive(1, XOR, 8'h0F, 8'hF0);
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (gq.size() >= 4) break;
    end
    @(posedge clk);
    #1;
    bus.req_valid = '0;
    wait_done("t3_done");
    chk("t3_grants", gq.size(), 4);
    for (int k = 0; k < gq.size(); k++) chk("t3_order", gq[k], k % 2);
    for (int k = 1; k < aq.size(); k++) chk("t3_spacing", aq[k] - aq[k-1], 3);

    // 4: backpressure on requester 1 while requester 0 waits
    bus.resp_ready = 3'b101;
    drive(1, ADD, 8'h33, 8'h44);
    wait_ready(1, "t4_ready");
    wait_rv(1, "t4_rv");
    for (int s = 0; s < 5; s++) begin
      @(posedge clk);
      #1;
      bus.resp_ready[0] = ~bus.resp_ready[0];
      if (s == 0) drive(0, ADD, 8'h01, 8'h02);
      @(negedge clk);
      chk("t4_stall_ready", 32'(bus.req_ready), 0);
      chk("t4_stall_rv", 32'(bus.resp_valid), 32'b010);
      chk("t4_stall_rslt", 32'(bus.resp_rslt), 32'h77);
    end
    @(posedge clk);
    #1;
    bus.resp_ready = 3'b111;
    @(negedge clk);
    chk("t4_last_rv", 32'(bus.resp_valid), 32'b010);
    @(posedge clk);
    #1;
    chk("t4_rv_cleared", 32'(bus.resp_valid), 0);
    chk("t4_pending_granted", 32'(bus.req_ready), 32'b001);
    wait_ready(0, "t4_r0_ready");
    expect_resp(0, 8'h03, 1'b0, "t4_r0");
    wait_done("t4_done");

    // 5: asynchronous reset during EXEC (ptr is 1 here)
    drive(0, ADD, 8'h10, 8'h01);
    wait_ready(0, "t5_ready");
    #2;
    rst_n = 1'b0;
    drive(0, XOR, 8'hAA, 8'h55);
    drive(1, RSH, 8'hFF, 8'h02);
    #1;
    check_zero_outs("t5_async");
    sb.delete();
    in_resp = 1'b0;
    mptr = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_grant0", 32'(bus.req_ready), 32'b001);
    @(posedge clk);
    #1;
    bus.req_valid[0] = 1'b0;
    expect_resp(0, 8'hFF, 1'b0, "t5_r0");
    wait_ready(1, "t5_r1_ready");
    expect_resp(1, 8'h3F, 1'b0, "t5_r1");
    wait_done("t5_done");

    // 6a: 1 and 2 arrive while 0 is in RESP; ptr=1 after granting 0
    gq.delete();
    bus.resp_ready = 3'b110;
    drive(0, ADD, 8'h07, 8'h08);
    wait_ready(0, "t6a_ready");
    wait_rv(0, "t6a_rv");
    @(posedge clk);
    #1;
    drive(1, XOR, 8'h03, 8'h05);
    drive(2, LSH, 8'h01, 8'h03);
    @(negedge clk);
    chk("t6a_stall_ready", 32'(bus.req_ready), 0);
    @(posedge clk);
    #1;
    bus.resp_ready = 3'b111;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("t6a_first_idle", 32'(bus.req_ready), 32'b010);
    @(posedge clk);
    #1;
    bus.req_valid[1] = 1'b0;
    expect_resp(1, 8'h06, 1'b0, "t6a_r1");
    wait_ready(2, "t6a_r2_ready");
    expect_resp(2, 8'h08, 1'b0, "t6a_r2");
    wait_done("t6a_done");
    chk("t6a_n", gq.size(), 3);
    for (int k = 0; k < gq.size(); k++) chk("t6a_order", gq[k], k);

    // 6b: 0 and 2 arrive while 1 is in RESP; ptr=2 so 2 wins
    gq.delete();
    bus.resp_ready = 3'b101;
    drive(1, RSH, 8'h40, 8'h01);
    wait_ready(1, "t6b_ready");
    wait_rv(1, "t6b_rv");
    @(posedge clk);
    #1;
    drive(0, ADD, 8'hFF, 8'h01);
    drive(2, XOR, 8'hC3, 8'h0F);
    @(posedge clk);
    #1;
    bus.resp_ready = 3'b111;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("t6b_first_idle", 32'(bus.req_ready), 32'b100);
    @(posedge clk);
    #1;
    bus.req_valid[2] = 1'b0;
    expect_resp(2, 8'hCC, 1'b0, "t6b_r2");
    wait_ready(0, "t6b_r0_ready");
    expect_resp(0, 8'h00, 1'b1, "t6b_r0");
    wait_done("t6b_done");
    chk("t6b_n", gq.size(), 3);
    if (gq.size() == 3) begin
      chk("t6b_o0", gq[0], 1);
      chk("t6b_o1", gq[1], 2);
      chk("t6b_o2", gq[2], 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
